bcd_display_scanner: RTL and testbench
======================================

# bcd_display_scanner

Converts an unsigned binary calculator result into four BCD digits using a sequential double-dabble conversion. It then time-multiplexes those digits onto a common-anode 4-digit display. It sits directly upstream of the BCD-to-seven-segment decoder: `digit_bcd` drives the decoder's 4-bit input, and `anode_n` drives the digit enables.

## Interface
- `BIN_W`, default 14: width of the binary input. The range 0..9999 fits in 14 bits.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled. Legal range is ≥ 2.
- `clk`  in  1: system clock. All state updates on the rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `value_in`  in  BIN_W: unsigned binary value to display. Sampled only when a load is accepted.
- `load`  in  1: single-cycle start strobe. Accepted only while `busy`=0.
- `busy`  out  1: high while a conversion is in progress.
- `overflow`  out  1: high when the last accepted `value_in` exceeded 9999. Registered alongside the display digits.
- `digit_bcd`  out  4: BCD nibble of the currently scanned digit. Feeds the decoder input.
- `anode_n`  out  4: active-low digit enables. Bit 0 is the ones digit and bit 3 is the thousands digit.

## Operation
- **Reset values:**
  - `busy`=0, `overflow`=0.
  - Display register = 0000, scan index = 0, refresh counter = 0.
  - `digit_bcd`=4'h0, `anode_n`=4'b1110.
- **Conversion FSM states:**
  - IDLE: `load`=1 → SHIFT. The shift register is loaded with `min(value_in, 9999)`, the BCD accumulator is cleared, the iteration counter is set to 0, `busy` is set, and the overflow flag (`value_in` > 9999) is captured internally.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, binary} left by 1 and increment the counter. On the BIN_W-th iteration, the shifted BCD result is written to the display register, `overflow` is updated, `busy` clears, and the FSM returns to IDLE.
  - `load` asserted while `busy`=1 is ignored. It is not queued.
- **Saturation:** inputs > 9999 display 9999 with `overflow`=1. Any accepted load ≤ 9999 clears `overflow`.
- **Scan:**
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On each wrap, the scan index advances 0→1→2→3→0.
  - Scanning is free-running and independent of conversion.
  - The display register changes only at conversion completion, so no partial values are ever shown.
- **Outputs per scan index i:**
  - `digit_bcd` = display nibble i.
  - `anode_n` = all ones except bit i low.
- **Leading-zero blanking:** digit i (i ≥ 1) is blanked (`anode_n`=4'b1111 for that slot) if it and all higher digits are 0. Digit 0 is never blanked, so 0 shows as a single "0". `digit_bcd` still carries the nibble (0) when the slot is blanked.
- **Reset mid-conversion:** the conversion is aborted immediately and the display returns to 0000. No completion occurs after reset release.

## Timing
- `load` sampled high at edge k, with `busy`=0:
  - `busy`=1 after edge k, through edge k+BIN_W-1.
  - Display register and `overflow` update at edge k+BIN_W, and `busy`=0 after that edge (14 cycles for the default).
- A new `load` is accepted at edge k+BIN_W+1 at the earliest. A load held high continuously restarts a conversion every BIN_W+1 cycles.
- The scan index changes once every REFRESH_DIV cycles. A full frame is 4×REFRESH_DIV cycles.
- `digit_bcd` and `anode_n` are registered and change on the same edge as the index. There are no glitches between them.
- `load` and a scan wrap in the same cycle are independent. Both take effect.

## Test plan
- **Reset:** assert `rst_n`=0 asynchronously mid-cycle → `anode_n`=4'b1110, `digit_bcd`=0, `busy`=0 immediately; the display holds 0 for a full frame.
- **Conversion and latency (REFRESH_DIV=4):** `load` with `value_in`=1234 at edge k → `busy` high for 14 cycles and low after edge k+14; the scan then yields (`anode_n`, `digit_bcd`) = (1110, 4), (1101, 3), (1011, 2), (0111, 1), each for 4 cycles.
- **Saturation:** `value_in`=16383 → digits 9,9,9,9 with `overflow`=1; a following load of 42 → `overflow`=0.
- **Leading-zero blanking:**
  - `value_in`=7 → slot 0 shows 7 with `anode_n`=1110; slots 1–3 show `anode_n`=1111.
  - `value_in`=1005 → all four slots are enabled, showing 5,0,0,1.
- **Load while busy:** load 1234, then pulse `load` with 5678 three cycles later → the display ends at 1234 and `busy` falls exactly once.
- **Reset mid-conversion:** load 9876, assert `rst_n`=0 at cycle 6 and release it → the display stays 0000, `busy`=0, and no later update occurs.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Sequential double-dabble binary-to-BCD converter feeding a free-running,
// leading-zero-blanked 4-digit common-anode display scanner.
module bcd_display_scanner #(
  parameter int unsigned BIN_W       = 14,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value_in,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  output logic [3:0]       digit_bcd,
  output logic [3:0]       anode_n
);

  localparam int unsigned BCD_W = 16;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned EXT_W = (BIN_W > 14) ? BIN_W : 14;

  localparam logic [EXT_W-1:0] MAX_VAL   = EXT_W'(9999);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_iter;
  logic               r_ovf_pend;
  logic [BCD_W-1:0]   r_disp;
  logic               r_busy;
  logic               r_overflow;
  logic [REF_W-1:0]   r_refresh;
  logic [1:0]         r_idx;
  logic [3:0]         r_digit;
  logic [3:0]         r_anode;

  logic [EXT_W-1:0]   w_val_ext;
  logic               w_in_ovf;
  logic [BIN_W-1:0]   w_sat;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_shift;
  logic               w_done;
  logic [BCD_W-1:0]   w_disp_nxt;
  logic               w_wrap;
  logic [1:0]         w_idx_nxt;
  logic [3:0]         w_blank;
  logic [3:0]         w_digit_nxt;
  logic [3:0]         w_anode_nxt;

  // Saturate out-of-range inputs to 9999 and remember that we did.
  assign w_val_ext = EXT_W'(value_in);
  assign w_in_ovf  = (w_val_ext > MAX_VAL);
  assign w_sat     = w_in_ovf ? BIN_W'(MAX_VAL) : value_in;

  // Add-3 correction on every nibble >= 5, then shift {bcd, bin} left by one.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_shift = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
  assign w_done      = (r_state == S_SHIFT) && (r_iter == LAST_ITER);
  assign w_disp_nxt  = w_done ? w_bcd_shift : r_disp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_ovf_pend <= 1'b0;
      r_disp     <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin      <= w_sat;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_ovf_pend <= w_in_ovf;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd  <= w_bcd_shift;
          r_bin  <= r_bin << 1;
          r_iter <= r_iter + CNT_W'(1);
          if (w_done) begin
            r_disp     <= w_bcd_shift;
            r_overflow <= r_ovf_pend;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Scan outputs are computed from next-cycle index/display so they stay aligned.
  assign w_wrap    = (r_refresh == REF_LAST);
  assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

  always_comb begin
    w_blank[0] = 1'b0;
    w_blank[1] = (w_disp_nxt[15:4]  == 12'd0);
    w_blank[2] = (w_disp_nxt[15:8]  == 8'd0);
    w_blank[3] = (w_disp_nxt[15:12] == 4'd0);
    case (w_idx_nxt)
      2'd0:    w_digit_nxt = w_disp_nxt[3:0];
      2'd1:    w_digit_nxt = w_disp_nxt[7:4];
      2'd2:    w_digit_nxt = w_disp_nxt[11:8];
      default: w_digit_nxt = w_disp_nxt[15:12];
    endcase
    w_anode_nxt = w_blank[w_idx_nxt] ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
      r_digit   <= 4'h0;
      r_anode   <= 4'b1110;
    end else begin
      r_refresh <= w_wrap ? '0 : r_refresh + REF_W'(1);
      r_idx     <= w_idx_nxt;
      r_digit   <= w_digit_nxt;
      r_anode   <= w_anode_nxt;
    end
  end

  assign busy      = r_busy;
  assign overflow  = r_overflow;
  assign digit_bcd = r_digit;
  assign anode_n   = r_anode;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: loads push expected digits, a
// monitor pops them on each conversion completion and checks a full scan frame.
module tb_bcd_display_scanner;

  localparam int unsigned BIN_W = 14;
  localparam int unsigned RDIV  = 4;

  logic             clk;
  logic             rst_n;
  logic [BIN_W-1:0] value_in;
  logic             load;
  logic             busy;
  logic             overflow;
  logic [3:0]       digit_bcd;
  logic [3:0]       anode_n;

  bcd_display_scanner #(.BIN_W(BIN_W), .REFRESH_DIV(RDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_in  (value_in),
    .load      (load),
    .busy      (busy),
    .overflow  (overflow),
    .digit_bcd (digit_bcd),
    .anode_n   (anode_n)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   n_done  = 0;
  int   n_falls = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_anode(input logic [15:0] d, input int i);
    logic [15:0] hi;
    hi = d >> (4 * i);
    if (i > 0 && hi == 16'd0) return 4'b1111;
    return ~(4'b0001 << i);
  endfunction

  // Align to the start of slot 0 and check all 16 cycles of one frame.
  task automatic check_frame(input logic [15:0] d, input string tag);
    logic [3:0] prev;
    int         t;
    logic [3:0] exp_d;
    bit         found;
    t = 0;
    found = 0;
    @(negedge clk);
    prev = anode_n;
    while (!found && t < 40) begin
      @(negedge clk);
      if (anode_n == 4'b1110 && prev != 4'b1110) found = 1;
      else prev = anode_n;
      t++;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s slot0_timeout actual=none expected=slot0", tag);
      return;
    end
    for (int c = 0; c < 4 * RDIV; c++) begin
      if (c > 0) @(negedge clk);
      exp_d = d[4*(c/RDIV) +: 4];
      chk({tag, "_anode"}, 32'(anode_n), 32'(exp_anode(d, c / RDIV)));
      chk({tag, "_digit"}, 32'(digit_bcd), 32'(exp_d));
    end
  endtask

  // Completion monitor: busy falling pops the scoreboard.
  initial begin
    logic pb;
    int   bc;
    exp_t e;
    pb = 1'b0;
    bc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb = 1'b0;
        bc = 0;
      end else begin
        if (busy) bc++;
        if (pb && !busy) begin
          chk("busy_cycles", 32'(bc), 32'(BIN_W));
          bc = 0;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion actual=completion expected=none");
          end else begin
            e = sb_q.pop_front();
            chk("overflow", 32'(overflow), 32'(e.ovf));
            check_frame(e.digits, "frame");
          end
          n_done++;
        end
        pb = busy;
      end
    end
  end

  // Independent busy-fall counter.
  initial begin
    logic fp;
    fp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && fp && !busy) n_falls++;
      fp = rst_n ? busy : 1'b0;
    end
  end

  task automatic do_load(input logic [BIN_W-1:0] v, input logic [15:0] d,
                         input logic o, input bit push);
    exp_t tmp;
    @(negedge clk);
    value_in = v;
    load     = 1'b1;
    if (push) begin
      tmp.digits = d;
      tmp.ovf    = o;
      sb_q.push_back(tmp);
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (n_done < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done", 32'(n_done), 32'(target));
  endtask

  initial begin
    rst_n    = 1'b1;
    load     = 1'b0;
    value_in = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_anode", 32'(anode_n), 32'hE);
    chk("rst_digit", 32'(digit_bcd), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_load(14'd1234,  16'h1234, 1'b0, 1'b1); wait_done(1);
    do_load(14'd16383, 16'h9999, 1'b1, 1'b1); wait_done(2);
    do_load(14'd42,    16'h0042, 1'b0, 1'b1); wait_done(3);
    do_load(14'd7,     16'h0007, 1'b0, 1'b1); wait_done(4);
    do_load(14'd1005,  16'h1005, 1'b0, 1'b1); wait_done(5);

    // Load while busy must be dropped.
    do_load(14'd1234, 16'h1234, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    value_in = 14'd5678;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done(6);
    repeat (30) @(negedge clk);
    chk("done_after_ignored", 32'(n_done), 32'd6);
    chk("falls_after_ignored", 32'(n_falls), 32'd6);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_anode", 32'(anode_n), 32'hE);
    chk("async_rst_digit", 32'(digit_bcd), 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000, "rst_frame");

    // Reset during a conversion aborts it.
    do_load(14'd9876, 16'h9876, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midconv_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000, "midconv_frame");
    repeat (20) @(negedge clk);
    chk("midconv_busy_after", 32'(busy), 32'd0);
    chk("midconv_done", 32'(n_done), 32'd6);
    chk("midconv_falls", 32'(n_falls), 32'd6);
    check_frame(16'h0000, "midconv_frame2");
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
